// File: rtl/sc_frogger_pkg.sv
// Shared Frogger game-flow definitions: state encoding, bus widths and the
// lane-speed helper used by the level sequencer.
package sc_frogger_pkg;

    localparam int LEVEL_W = 4;
    localparam int SPEED_W = 28;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        ADVANCE = 3'd2,
        DEATH   = 3'd3,
        WON     = 3'd4,
        LOST    = 3'd5
    } state_t;

    // Lane divisor for a level: base minus level*step, floored at min.
    // Worked in 32 bits so a product larger than the base reads as underflow.
    function automatic logic [SPEED_W-1:0] speed_for_level(
        input logic [LEVEL_W-1:0] level,
        input int unsigned        base,
        input int unsigned        step,
        input int unsigned        min_speed
    );
        logic [31:0] product;
        logic [31:0] result;
        product = {{(32-LEVEL_W){1'b0}}, level} * step;
        if (product > base) begin
            result = min_speed;
        end else begin
            result = base - product;
            if (result < min_speed) begin
                result = min_speed;
            end
        end
        return result[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/sc_hold_timer.sv
// Loadable down-counter with a zero flag; counts a pause length and then
// parks at zero until reloaded. Used for every timed pause in the game.
module sc_hold_timer #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise decrement until zero and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sc_level_sequencer.sv
// Frogger game-flow controller: turns goal/collision/start edges into
// level-counter pulses, tracks lives, gates play and picks the lane speed.
module sc_level_sequencer
    import sc_frogger_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned MAX_LEVEL   = 9,
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned SPEED_BASE  = 12500000,
    parameter int unsigned SPEED_STEP  = 1000000,
    parameter int unsigned SPEED_MIN   = 2000000
) (
    input  logic               SC_LEVELSEQ_CLOCK_50,
    input  logic               SC_LEVELSEQ_RESET_InLow,
    input  logic               SC_LEVELSEQ_START_InLow,
    input  logic               SC_LEVELSEQ_GOAL,
    input  logic               SC_LEVELSEQ_COLLISION,
    input  logic [LEVEL_W-1:0] SC_LEVELSEQ_LEVEL_InBUS,
    output logic               SC_LEVELSEQ_CUENTA,
    output logic               SC_LEVELSEQ_LEVELCLEAR,
    output logic               SC_LEVELSEQ_FROGRESET,
    output logic               SC_LEVELSEQ_RUN,
    output logic [2:0]         SC_LEVELSEQ_LIVES_OutBUS,
    output logic [SPEED_W-1:0] SC_LEVELSEQ_SPEED_OutBUS,
    output logic               SC_LEVELSEQ_WON,
    output logic               SC_LEVELSEQ_LOST
);

    // Wide enough to hold HOLD_CYCLES-1.
    localparam int TIMER_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]         LIVES_START = 3'(LIVES_INIT);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(MAX_LEVEL);

    logic   clk;
    logic   rst_n;
    state_t state;

    logic   goal_prev, coll_prev, start_prev;
    logic   goal_evt, coll_evt, start_evt;

    logic   timer_load;
    logic   timer_dec;
    logic   timer_zero;

    assign clk   = SC_LEVELSEQ_CLOCK_50;
    assign rst_n = SC_LEVELSEQ_RESET_InLow;

    // Registered rising-edge detectors; START is active-low so its press is
    // a falling edge of the pin.
    // NOTE: non-blocking assignments let every register sample the previous
    // value of its neighbours, which is what makes prev/evt a true edge pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            goal_prev  <= 1'b0;
            coll_prev  <= 1'b0;
            start_prev <= 1'b0;
            goal_evt   <= 1'b0;
            coll_evt   <= 1'b0;
            start_evt  <= 1'b0;
        end else begin
            goal_prev  <= SC_LEVELSEQ_GOAL;
            coll_prev  <= SC_LEVELSEQ_COLLISION;
            start_prev <= ~SC_LEVELSEQ_START_InLow;
            goal_evt   <= SC_LEVELSEQ_GOAL & ~goal_prev;
            coll_evt   <= SC_LEVELSEQ_COLLISION & ~coll_prev;
            start_evt  <= ~SC_LEVELSEQ_START_InLow & ~start_prev;
        end
    end

    // The pause timer is (re)loaded whenever PLAY acts on an event; loading
    // on the way to WON/LOST is harmless since those states ignore it.
    assign timer_load = (state == PLAY) && (coll_evt || goal_evt);
    assign timer_dec  = (state == ADVANCE) || (state == DEATH);

    sc_hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (HOLD_LOAD),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    // Game-flow FSM with registered pulse and status outputs; pulses default
    // low every cycle so each one lasts exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= IDLE;
            SC_LEVELSEQ_CUENTA       <= 1'b0;
            SC_LEVELSEQ_LEVELCLEAR   <= 1'b0;
            SC_LEVELSEQ_FROGRESET    <= 1'b0;
            SC_LEVELSEQ_RUN          <= 1'b0;
            SC_LEVELSEQ_LIVES_OutBUS <= 3'd0;
            SC_LEVELSEQ_WON          <= 1'b0;
            SC_LEVELSEQ_LOST         <= 1'b0;
        end else begin
            SC_LEVELSEQ_CUENTA     <= 1'b0;
            SC_LEVELSEQ_LEVELCLEAR <= 1'b0;
            SC_LEVELSEQ_FROGRESET  <= 1'b0;
            case (state)
                IDLE, WON, LOST: begin
                    if (start_evt) begin
                        SC_LEVELSEQ_LIVES_OutBUS <= LIVES_START;
                        SC_LEVELSEQ_LEVELCLEAR   <= 1'b1;
                        SC_LEVELSEQ_FROGRESET    <= 1'b1;
                        SC_LEVELSEQ_RUN          <= 1'b1;
                        SC_LEVELSEQ_WON          <= 1'b0;
                        SC_LEVELSEQ_LOST         <= 1'b0;
                        state                    <= PLAY;
                    end
                end
                PLAY: begin
                    if (coll_evt) begin
                        // Collision wins over a goal seen in the same cycle.
                        SC_LEVELSEQ_LIVES_OutBUS <= SC_LEVELSEQ_LIVES_OutBUS - 3'd1;
                        SC_LEVELSEQ_RUN          <= 1'b0;
                        if (SC_LEVELSEQ_LIVES_OutBUS == 3'd1) begin
                            SC_LEVELSEQ_LOST <= 1'b1;
                            state            <= LOST;
                        end else begin
                            SC_LEVELSEQ_FROGRESET <= 1'b1;
                            state                 <= DEATH;
                        end
                    end else if (goal_evt) begin
                        SC_LEVELSEQ_RUN <= 1'b0;
                        if (SC_LEVELSEQ_LEVEL_InBUS == LAST_LEVEL) begin
                            SC_LEVELSEQ_WON <= 1'b1;
                            state           <= WON;
                        end else begin
                            SC_LEVELSEQ_CUENTA <= 1'b1;
                            state              <= ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    if (timer_zero) begin
                        SC_LEVELSEQ_FROGRESET <= 1'b1;
                        SC_LEVELSEQ_RUN       <= 1'b1;
                        state                 <= PLAY;
                    end
                end
                DEATH: begin
                    // The frog was already sent home when the hit was seen.
                    if (timer_zero) begin
                        SC_LEVELSEQ_RUN <= 1'b1;
                        state           <= PLAY;
                    end
                end
                default: begin
                    SC_LEVELSEQ_RUN <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

    // Lane divisor follows the level counter directly, no register.
    assign SC_LEVELSEQ_SPEED_OutBUS = speed_for_level(SC_LEVELSEQ_LEVEL_InBUS,
                                                      SPEED_BASE, SPEED_STEP,
                                                      SPEED_MIN);

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Scoreboard bench for the level sequencer: expected pulse cycles are queued
// before stimulus; a negedge monitor pops one entry per pulse cycle.
module tb_sc_level_sequencer;

    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_n;
    logic        goal;
    logic        coll;
    logic [3:0]  level;
    logic        cuenta, levelclear, frogreset, run, won, lost;
    logic [2:0]  lives;
    logic [27:0] speed;

    // Snapshot of the outputs during a pulse cycle.
    typedef struct packed {
        logic       cu;
        logic       lc;
        logic       fr;
        logic       run;
        logic [2:0] lives;
        logic       won;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sc_level_sequencer #(
        .LIVES_INIT  (3),
        .MAX_LEVEL   (9),
        .HOLD_CYCLES (HOLD),
        .SPEED_BASE  (12500000),
        .SPEED_STEP  (1000000),
        .SPEED_MIN   (2000000)
    ) dut (
        .SC_LEVELSEQ_CLOCK_50     (clk),
        .SC_LEVELSEQ_RESET_InLow  (rst_n),
        .SC_LEVELSEQ_START_InLow  (start_n),
        .SC_LEVELSEQ_GOAL         (goal),
        .SC_LEVELSEQ_COLLISION    (coll),
        .SC_LEVELSEQ_LEVEL_InBUS  (level),
        .SC_LEVELSEQ_CUENTA       (cuenta),
        .SC_LEVELSEQ_LEVELCLEAR   (levelclear),
        .SC_LEVELSEQ_FROGRESET    (frogreset),
        .SC_LEVELSEQ_RUN          (run),
        .SC_LEVELSEQ_LIVES_OutBUS (lives),
        .SC_LEVELSEQ_SPEED_OutBUS (speed),
        .SC_LEVELSEQ_WON          (won),
        .SC_LEVELSEQ_LOST         (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic cu, input logic lc, input logic fr,
                                input logic r, input logic [2:0] lv,
                                input logic w, input logic l);
        exp_t e;
        e.cu = cu; e.lc = lc; e.fr = fr; e.run = r;
        e.lives = lv; e.won = w; e.lost = l;
        return e;
    endfunction

    // Counts the RUN-low cycles starting at the next negedge; returns at the
    // first negedge where RUN is high again.
    task automatic measure_hold(input string name, input int required);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (run) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        check({name, "_resumed"}, 32'(seen), 32'd1);
        check(name, 32'(n), 32'(required));
    endtask

    task automatic press_start();
        start_n = 1'b0;
        tick(1);
        start_n = 1'b1;
        tick(2);
    endtask

    // Monitor: every cycle with a pulse consumes one expected snapshot.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst_n === 1'b1 && (cuenta || levelclear || frogreset)) begin
            got = {cuenta, levelclear, frogreset, run, lives, won, lost};
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(got), 32'd0);
            end else begin
                want = exp_q.pop_front();
                check("pulse_snapshot", 32'(got), 32'(want));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lv_tab [6] = '{0, 5, 9, 10, 11, 15};
        int unsigned sp_tab [6] = '{12500000, 7500000, 3500000, 2500000, 2000000, 2000000};

        rst_n   = 1'b0;
        start_n = 1'b1;
        goal    = 1'b0;
        coll    = 1'b0;
        level   = 4'd0;
        tick(2);
        check("rst_run",   32'(run),   32'd0);
        check("rst_lives", 32'(lives), 32'd0);
        check("rst_pulses", 32'({cuenta, levelclear, frogreset}), 32'd0);
        check("rst_won_lost", 32'({won, lost}), 32'd0);
        rst_n = 1'b1;
        tick(3);
        check("idle_run", 32'(run), 32'd0);

        // New game from IDLE.
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
        press_start();
        tick(1);
        check("start_run",   32'(run),   32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_clear_gone", 32'(levelclear), 32'd0);

        // Goal at level 2: CUENTA two clocks after GOAL rises, 4-cycle pause,
        // FROGRESET as play resumes; GOAL kept high gives no second count.
        level = 4'd2;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
        goal = 1'b1;
        tick(1);
        check("goal_latency_early", 32'(cuenta), 32'd0);
        tick(1);
        check("goal_latency", 32'(cuenta), 32'd1);
        measure_hold("advance_hold", 4);
        tick(6);
        check("goal_held_run", 32'(run), 32'd1);
        goal  = 1'b0;
        tick(2);

        // Goal and collision together: collision wins.
        level = 4'd3;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0));
        goal = 1'b1;
        coll = 1'b1;
        tick(2);
        check("both_lives", 32'(lives), 32'd2);
        check("both_no_cuenta", 32'(cuenta), 32'd0);
        measure_hold("death_hold", 4);
        tick(1);
        goal = 1'b0;
        coll = 1'b0;
        tick(2);

        // Second collision: 2 -> 1.
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0));
        coll = 1'b1;
        tick(2);
        check("coll2_lives", 32'(lives), 32'd1);
        measure_hold("death_hold2", 4);
        tick(1);
        coll = 1'b0;
        tick(2);

        // Third collision at one life: LOST, no frog reset.
        coll = 1'b1;
        tick(2);
        check("lost_flag",  32'(lost),  32'd1);
        check("lost_lives", 32'(lives), 32'd0);
        check("lost_run",   32'(run),   32'd0);
        coll = 1'b0;
        tick(3);
        check("lost_stays", 32'(lost), 32'd1);

        // New game from LOST.
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
        press_start();
        tick(1);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_lost_clear", 32'(lost), 32'd0);

        // Goal on the last level: WON without a count pulse.
        level = 4'd9;
        goal  = 1'b1;
        tick(2);
        check("won_flag", 32'(won), 32'd1);
        check("won_run",  32'(run), 32'd0);
        check("won_no_cuenta", 32'(cuenta), 32'd0);
        goal = 1'b0;

        // Lane divisor versus level, including the clamp.
        for (int i = 0; i < 6; i++) begin
            level = 4'(lv_tab[i]);
            #1;
            check($sformatf("speed_l%0d", lv_tab[i]), 32'(speed), sp_tab[i]);
        end

        // New game from WON.
        level = 4'd0;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0));
        press_start();
        tick(1);
        check("rewon_clear", 32'(won), 32'd0);

        // Reset in the middle of an ADVANCE pause drops the pending pulse.
        level = 4'd1;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
        goal = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("midrst_run",    32'(run),   32'd0);
        check("midrst_lives",  32'(lives), 32'd0);
        check("midrst_pulses", 32'({cuenta, levelclear, frogreset}), 32'd0);
        check("midrst_won_lost", 32'({won, lost}), 32'd0);
        goal = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_idle_run",   32'(run),   32'd0);
        check("post_rst_idle_lives", 32'(lives), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
